// File: rtl/pipe_flow_pkg.sv
// Shared types and constants for the pipe flow controller: FSM state encoding,
// default block/FIFO geometry and counter widths.
package pipe_flow_pkg;

    typedef enum logic [1:0] {
        StRst  = 2'd0,
        StWait = 2'd1,
        StIdle = 2'd2,
        StRun  = 2'd3
    } state_e;

    localparam int unsigned DefBlockWords   = 128;
    localparam int unsigned DefInDepth      = 1024;
    localparam int unsigned DefRstCycles    = 8;
    localparam int unsigned DefSettleCycles = 4;

    localparam int unsigned BlkCntW = 16;
    localparam int unsigned LevelW  = 10;

    // Bits needed to hold values 0 .. max(a, b)-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/pipe_block_counter.sv
// Word counter modulo WORDS plus a wrapping 16-bit completed-block count.
// The block count exists only when PIPE_FLOW_STATS_EN is defined; otherwise it reads 0.
module pipe_block_counter
    import pipe_flow_pkg::*;
#(
    parameter int unsigned WORDS = DefBlockWords
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               inc,
    output logic [BlkCntW-1:0] blocks
);

    localparam int unsigned    WordW    = cnt_width(WORDS, 1);
    localparam logic [WordW-1:0] LastWord = WordW'(WORDS - 1);

    logic [WordW-1:0] word_q;
    logic             wrap;

    assign wrap = inc && (word_q == LastWord);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
        end else if (clr) begin
            word_q <= '0;
        end else if (inc) begin
            word_q <= wrap ? '0 : word_q + 1'b1;
        end
    end

`ifdef PIPE_FLOW_STATS_EN
    logic [BlkCntW-1:0] blocks_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blocks_q <= '0;
        end else if (clr) begin
            blocks_q <= '0;
        end else if (wrap) begin
            blocks_q <= blocks_q + 1'b1;
        end
    end

    assign blocks = blocks_q;
`else
    assign blocks = '0;
`endif

endmodule

// File: rtl/pipe_flow_ctrl.sv
// Host pipe flow controller: FIFO reset/settle sequencing, block-ready flags,
// sticky protocol error and block statistics (block counts need PIPE_FLOW_STATS_EN).
module pipe_flow_ctrl
    import pipe_flow_pkg::*;
#(
    parameter int unsigned BLOCK_WORDS   = DefBlockWords,
    parameter int unsigned IN_DEPTH      = DefInDepth,
    parameter int unsigned RST_CYCLES    = DefRstCycles,
    parameter int unsigned SETTLE_CYCLES = DefSettleCycles
) (
    input  logic               okClk,
    input  logic               rst_n,
    input  logic               sw_rst,
    input  logic               stream_req,
    input  logic [LevelW-1:0]  in_wr_count,
    input  logic               in_full,
    input  logic [LevelW-1:0]  out_rd_count,
    input  logic               out_empty,
    input  logic               pi_write,
    input  logic               po_read,
    output logic               pi_ready,
    output logic               po_ready,
    output logic               fifo_rst,
    output logic               stream_en,
    output logic [1:0]         state,
    output logic               err,
    output logic [BlkCntW-1:0] blocks_in,
    output logic [BlkCntW-1:0] blocks_out
);

    localparam int unsigned      CntW       = cnt_width(RST_CYCLES, SETTLE_CYCLES);
    localparam logic [CntW-1:0]  RstLoad    = CntW'(RST_CYCLES - 1);
    localparam logic [CntW-1:0]  SettleLoad = CntW'(SETTLE_CYCLES - 1);
    localparam logic [LevelW-1:0] PiLimit   = LevelW'(IN_DEPTH - BLOCK_WORDS);
    localparam logic [LevelW-1:0] PoLimit   = LevelW'(BLOCK_WORDS);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            pi_ready_q, po_ready_q, err_q;
    logic            active, in_rst, err_set;

    always_ff @(posedge okClk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRst;
            cnt_q   <= RstLoad;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (sw_rst) begin
            state_d = StRst;
            cnt_d   = RstLoad;
        end else begin
            unique case (state_q)
                StRst: begin
                    if (cnt_q == '0) begin
                        state_d = StWait;
                        cnt_d   = SettleLoad;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                StIdle: if (stream_req) state_d = StRun;
                StRun:  if (!stream_req) state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        fifo_rst  = 1'b0;
        stream_en = 1'b0;
        unique case (state_q)
            StRst:   fifo_rst  = 1'b1;
            StRun:   stream_en = 1'b1;
            default: ;
        endcase
    end

    assign active = (state_q == StIdle) || (state_q == StRun);
    assign in_rst = (state_q == StRst);

    // Strobes outside IDLE/RUN are errors; a strobe during RST wins over the RST clear.
    assign err_set = (pi_write && (in_full || !active)) || (po_read && (out_empty || !active));

    always_ff @(posedge okClk or negedge rst_n) begin
        if (!rst_n) begin
            pi_ready_q <= 1'b0;
            po_ready_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            pi_ready_q <= active && (in_wr_count <= PiLimit);
            po_ready_q <= active && (out_rd_count >= PoLimit);
            err_q      <= (in_rst ? 1'b0 : err_q) | err_set;
        end
    end

    pipe_block_counter #(
        .WORDS (BLOCK_WORDS)
    ) u_in_cnt (
        .clk    (okClk),
        .rst_n  (rst_n),
        .clr    (in_rst),
        .inc    (pi_write && active),
        .blocks (blocks_in)
    );

    pipe_block_counter #(
        .WORDS (BLOCK_WORDS)
    ) u_out_cnt (
        .clk    (okClk),
        .rst_n  (rst_n),
        .clr    (in_rst),
        .inc    (po_read && active),
        .blocks (blocks_out)
    );

    assign pi_ready = pi_ready_q;
    assign po_ready = po_ready_q;
    assign err      = err_q;
    assign state    = state_q;

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Self-checking bench for pipe_flow_ctrl: directed scenarios plus a randomized run
// checked against a cycle-count based behavioural model.
module tb_pipe_flow_ctrl;

    localparam int BW    = 128;
    localparam int DEPTH = 1024;
    localparam int RC    = 8;
    localparam int SC    = 4;
`ifdef PIPE_FLOW_STATS_EN
    localparam bit Stats = 1'b1;
`else
    localparam bit Stats = 1'b0;
`endif

    logic        okClk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sw_rst, stream_req, in_full, out_empty, pi_write, po_read;
    logic [9:0]  in_wr_count, out_rd_count;
    logic        pi_ready, po_ready, fifo_rst, stream_en, err;
    logic [1:0]  state;
    logic [15:0] blocks_in, blocks_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 okClk = ~okClk;

    pipe_flow_ctrl #(
        .BLOCK_WORDS   (BW),
        .IN_DEPTH      (DEPTH),
        .RST_CYCLES    (RC),
        .SETTLE_CYCLES (SC)
    ) dut (
        .okClk        (okClk),
        .rst_n        (rst_n),
        .sw_rst       (sw_rst),
        .stream_req   (stream_req),
        .in_wr_count  (in_wr_count),
        .in_full      (in_full),
        .out_rd_count (out_rd_count),
        .out_empty    (out_empty),
        .pi_write     (pi_write),
        .po_read      (po_read),
        .pi_ready     (pi_ready),
        .po_ready     (po_ready),
        .fifo_rst     (fifo_rst),
        .stream_en    (stream_en),
        .state        (state),
        .err          (err),
        .blocks_in    (blocks_in),
        .blocks_out   (blocks_out)
    );

    // Model: m_t = edges since entering RST; IDLE/RUN once RC+SC edges have elapsed.
    int     m_t;
    bit     m_run, m_err, m_pir, m_por;
    longint m_pi, m_po;

    function automatic logic [1:0] exp_state();
        if (m_t < RC) return 2'd0;
        if (m_t < RC + SC) return 2'd1;
        return m_run ? 2'd3 : 2'd2;
    endfunction

    function automatic bit exp_err_set();
        bit act;
        act = (exp_state() >= 2'd2);
        return (pi_write && (in_full || !act)) || (po_read && (out_empty || !act));
    endfunction

    always @(posedge okClk or negedge rst_n) begin
        if (!rst_n) begin
            m_t <= 0; m_run <= 1'b0; m_err <= 1'b0; m_pir <= 1'b0; m_por <= 1'b0;
            m_pi <= 0; m_po <= 0;
        end else begin
            m_err <= (exp_state() == 2'd0) ? exp_err_set() : (m_err || exp_err_set());
            if (exp_state() == 2'd0) begin
                m_pi <= 0;
                m_po <= 0;
            end else if (exp_state() >= 2'd2) begin
                if (pi_write) m_pi <= m_pi + 1;
                if (po_read) m_po <= m_po + 1;
            end
            m_pir <= (exp_state() >= 2'd2) && (int'(in_wr_count) <= DEPTH - BW);
            m_por <= (exp_state() >= 2'd2) && (int'(out_rd_count) >= BW);
            if (sw_rst) begin
                m_t   <= 0;
                m_run <= 1'b0;
            end else begin
                m_run <= (exp_state() >= 2'd2) && stream_req;
                if (m_t < 1000) m_t <= m_t + 1;
            end
        end
    end

    task automatic tick();
        @(posedge okClk);
        @(negedge okClk);
    endtask

    task automatic test_reset();
        int k;
        sw_rst = 0; stream_req = 0; in_full = 0; out_empty = 1; pi_write = 0; po_read = 0;
        in_wr_count = 0; out_rd_count = 0;
        rst_n = 0;
        tick(); tick();
        n_checks++;
        if (state !== 2'd0 || fifo_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d fifo_rst=%b, want state=0 fifo_rst=1", state, fifo_rst);
        end
        n_checks++;
        if (pi_ready !== 1'b0 || po_ready !== 1'b0 || err !== 1'b0 || stream_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: pi=%b po=%b err=%b en=%b, want all 0", pi_ready, po_ready, err, stream_en);
        end
        n_checks++;
        if (blocks_in !== 16'd0 || blocks_out !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_blocks: in=%0d out=%0d, want 0", blocks_in, blocks_out);
        end
        rst_n = 1;
        k = 0;
        while (fifo_rst === 1'b1 && k < 50) begin k++; tick(); end
        n_checks++;
        if (k != RC) begin
            n_fail++;
            $display("FAIL rst_cycles: fifo_rst high %0d cycles, want %0d", k, RC);
        end
        k = 0;
        while (state === 2'd1 && k < 50) begin k++; tick(); end
        n_checks++;
        if (k != SC) begin
            n_fail++;
            $display("FAIL wait_cycles: WAIT lasted %0d cycles, want %0d", k, SC);
        end
        n_checks++;
        if (state !== 2'd2 || pi_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_entry: state=%0d pi_ready=%b, want 2 and 0", state, pi_ready);
        end
        tick();
        n_checks++;
        if (pi_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL pi_ready_latency: got %b want 1", pi_ready);
        end
    endtask

    task automatic test_pi_ready();
        in_wr_count = 10'd896; tick();
        n_checks++;
        if (pi_ready !== 1'b1) begin n_fail++; $display("FAIL pi_ready_896: got %b want 1", pi_ready); end
        in_wr_count = 10'd897; tick();
        n_checks++;
        if (pi_ready !== 1'b0) begin n_fail++; $display("FAIL pi_ready_897: got %b want 0", pi_ready); end
        in_wr_count = 10'd0; tick();
        n_checks++;
        if (pi_ready !== 1'b1) begin n_fail++; $display("FAIL pi_ready_0: got %b want 1", pi_ready); end
    endtask

    task automatic test_po_ready();
        out_empty = 0;
        out_rd_count = 10'd127; tick();
        n_checks++;
        if (po_ready !== 1'b0) begin n_fail++; $display("FAIL po_ready_127: got %b want 0", po_ready); end
        out_rd_count = 10'd128; tick();
        n_checks++;
        if (po_ready !== 1'b1) begin n_fail++; $display("FAIL po_ready_128: got %b want 1", po_ready); end
        po_read = 1;
        repeat (256) tick();
        po_read = 0;
        tick();
        n_checks++;
        if (blocks_out !== (Stats ? 16'd2 : 16'd0)) begin
            n_fail++;
            $display("FAIL blocks_out_256: got %0d want %0d", blocks_out, Stats ? 2 : 0);
        end
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL po_no_err: got %b want 0", err); end
    endtask

    task automatic test_stream();
        stream_req = 1; tick();
        n_checks++;
        if (state !== 2'd3 || stream_en !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_on: state=%0d en=%b, want 3 and 1", state, stream_en);
        end
        stream_req = 0; tick();
        n_checks++;
        if (state !== 2'd2 || stream_en !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_off: state=%0d en=%b, want 2 and 0", state, stream_en);
        end
    endtask

    task automatic test_sw_rst();
        stream_req = 1; tick();
        pi_write = 1;
        repeat (200) tick();
        pi_write = 0;
        n_checks++;
        if (blocks_in !== (Stats ? 16'd1 : 16'd0)) begin
            n_fail++;
            $display("FAIL blocks_in_200: got %0d want %0d", blocks_in, Stats ? 1 : 0);
        end
        sw_rst = 1; tick();
        sw_rst = 0;
        n_checks++;
        if (state !== 2'd0 || fifo_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL swrst_state: state=%0d fifo_rst=%b, want 0 and 1", state, fifo_rst);
        end
        tick();
        n_checks++;
        if (blocks_in !== 16'd0 || blocks_out !== 16'd0 || pi_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL swrst_clear: in=%0d out=%0d pi_ready=%b, want 0 0 0", blocks_in, blocks_out, pi_ready);
        end
        stream_req = 0;
        repeat (12) tick();
        n_checks++;
        if (state !== 2'd2 || pi_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL swrst_recover: state=%0d pi_ready=%b, want 2 and 1", state, pi_ready);
        end
        // 72 leftover words would complete a block here if the word counter kept them.
        pi_write = 1; repeat (56) tick(); pi_write = 0;
        n_checks++;
        if (blocks_in !== 16'd0) begin n_fail++; $display("FAIL word_cleared: got %0d want 0", blocks_in); end
        pi_write = 1; repeat (72) tick(); pi_write = 0;
        n_checks++;
        if (blocks_in !== (Stats ? 16'd1 : 16'd0)) begin
            n_fail++;
            $display("FAIL blocks_in_128: got %0d want %0d", blocks_in, Stats ? 1 : 0);
        end
    endtask

    task automatic test_err();
        out_empty = 1; po_read = 1; tick(); po_read = 0;
        n_checks++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b want 1", err); end
        out_empty = 0; stream_req = 1;
        repeat (5) tick();
        stream_req = 0; tick();
        n_checks++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", err); end
        sw_rst = 1; tick(); sw_rst = 0; tick();
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b want 0", err); end
        repeat (8) tick();
        n_checks++;
        if (state !== 2'd1) begin n_fail++; $display("FAIL err_in_wait: state=%0d want 1", state); end
        pi_write = 1; tick(); pi_write = 0;
        n_checks++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL err_wait_strobe: got %b want 1", err); end
        repeat (5) tick();
        n_checks++;
        if (state !== 2'd2 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_after_wait: state=%0d err=%b, want 2 and 1", state, err);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            n_checks++;
            if (state !== exp_state() || fifo_rst !== (exp_state() == 2'd0)
                || stream_en !== (exp_state() == 2'd3)) begin
                n_fail++;
                $display("FAIL rnd_state @%0d: state=%0d rst=%b en=%b, want state=%0d", i, state,
                         fifo_rst, stream_en, exp_state());
            end
            n_checks++;
            if (pi_ready !== m_pir || po_ready !== m_por || err !== m_err) begin
                n_fail++;
                $display("FAIL rnd_flags @%0d: pi=%b po=%b err=%b, want %b %b %b", i, pi_ready,
                         po_ready, err, m_pir, m_por, m_err);
            end
            n_checks++;
            if (blocks_in !== (Stats ? 16'(m_pi / BW) : 16'd0)
                || blocks_out !== (Stats ? 16'(m_po / BW) : 16'd0)) begin
                n_fail++;
                $display("FAIL rnd_blocks @%0d: in=%0d out=%0d, want %0d %0d", i, blocks_in,
                         blocks_out, Stats ? m_pi / BW : 0, Stats ? m_po / BW : 0);
            end
            if (!rst_n) rst_n = 1;
            else if ($urandom_range(0, 999) == 0) rst_n = 0;
            sw_rst = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 19) == 0) stream_req = ~stream_req;
            in_wr_count  = $urandom_range(0, 1) ? 10'($urandom_range(880, 912))
                                                : 10'($urandom_range(0, 1023));
            out_rd_count = $urandom_range(0, 1) ? 10'($urandom_range(120, 136))
                                                : 10'($urandom_range(0, 1023));
            in_full   = ($urandom_range(0, 99) == 0);
            out_empty = ($urandom_range(0, 99) == 0);
            pi_write  = $urandom_range(0, 1) == 1;
            po_read   = $urandom_range(0, 1) == 1;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_pi_ready();
        test_po_ready();
        test_stream();
        test_sw_rst();
        test_err();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
